feature_unloader: RTL

- Read-side counterpart of the element-addressable feature loader.
- Snapshots a parallel element vector (array/accumulator results) on a capture pulse.
- Streams a selected element window out as wide, MSB-first packed words over a valid/ready handshake for writeback to feature memory.
- Element packing and element-index addressing match the loader's write convention, so unloaded words can be written straight back.

---
 rtl/feature_unloader.sv | 113 +++++++++++
 1 files changed

// File: rtl/feature_unloader.sv
// Snapshots a parallel element vector on capture and streams a selected element
// window out as MSB-first packed words over a valid/ready handshake.
module feature_unloader #(
    parameter int outputWidth  = 256,
    parameter int addrWidth    = 8,
    parameter int elementWidth = 8,
    parameter int numElements  = 128
) (
    input  logic                                      clk,
    input  logic                                      nrst,
    input  logic [numElements-1:0][elementWidth-1:0]  data_i,
    input  logic                                      capture_i,
    input  logic [9:0]                                start_idx,
    input  logic [9:0]                                end_idx,
    output logic [outputWidth-1:0]                    data_o,
    output logic [addrWidth-1:0]                      addr_o,
    output logic                                      valid_o,
    input  logic                                      ready_i,
    output logic                                      last_o,
    output logic                                      busy_o,
    output logic                                      done_o
);

    localparam int EPW    = outputWidth / elementWidth;
    localparam int PTR_W  = 11;
    localparam int EIDX_W = $clog2(numElements);

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    state_t                                   state;
    logic [numElements-1:0][elementWidth-1:0] cap_buf;
    logic [PTR_W-1:0]                         ptr;
    logic [PTR_W-1:0]                         end_q;
    logic [PTR_W-1:0]                         end_eff;
    logic                                     nonempty;
    logic                                     last;

    // Window end saturates at the vector length so the pointer never indexes past the buffer.
    function automatic logic [PTR_W-1:0] clamp_end(input logic [9:0] e);
        if ({1'b0, e} > PTR_W'(numElements))
            return PTR_W'(numElements);
        else
            return {1'b0, e};
    endfunction

    // Element ptr+i lands in slot i counted from the MSB; elements at or past end read as zero.
    function automatic logic [outputWidth-1:0] pack_word(
        input logic [numElements-1:0][elementWidth-1:0] b,
        input logic [PTR_W-1:0]                         p,
        input logic [PTR_W-1:0]                         e
    );
        logic [outputWidth-1:0] w;
        logic [PTR_W-1:0]       idx;
        w = '0;
        for (int i = 0; i < EPW; i++) begin
            idx = p + PTR_W'(i);
            if (idx < e && idx < PTR_W'(numElements))
                w[(EPW-1-i)*elementWidth +: elementWidth] = b[idx[EIDX_W-1:0]];
        end
        return w;
    endfunction

    assign end_eff  = clamp_end(end_idx);
    assign nonempty = end_eff > {1'b0, start_idx};

    assign valid_o = (state == DRAIN);
    assign busy_o  = valid_o;
    assign last    = (ptr + PTR_W'(EPW)) >= end_q;
    assign last_o  = valid_o & last;
    assign data_o  = valid_o ? pack_word(cap_buf, ptr, end_q) : '0;
    assign addr_o  = valid_o ? ptr[addrWidth-1:0] : '0;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= IDLE;
            cap_buf <= '0;
            ptr     <= '0;
            end_q   <= '0;
            done_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (capture_i) begin
                        cap_buf <= data_i;
                        end_q   <= end_eff;
                        ptr     <= {1'b0, start_idx};
                        if (nonempty)
                            state <= DRAIN;
                        else
                            done_o <= 1'b1;
                    end
                end
                DRAIN: begin
                    // Captures are ignored here, including one coinciding with the final transfer.
                    if (ready_i) begin
                        if (last) begin
                            state  <= IDLE;
                            done_o <= 1'b1;
                        end else begin
                            ptr <= ptr + PTR_W'(EPW);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
